// File: rtl/op_pipe_pkg.sv
// Shared constants for the op_pipe operation unit: op-code encodings and
// the width/ceiling of the saturating result counter.
package op_pipe_pkg;

  localparam logic [1:0] OP_LOGIC  = 2'b00;
  localparam logic [1:0] OP_PARITY = 2'b01;
  localparam logic [1:0] OP_ADD    = 2'b10;
  localparam logic [1:0] OP_SUB    = 2'b11;

  localparam int unsigned        CNT_W   = 8;
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

endpackage : op_pipe_pkg

// File: rtl/op_pipe_alu.sv
// Combinational two-operand operation: primary result y and secondary result z
// selected by op (logic, parity, add with carry, subtract with borrow).
module op_pipe_alu
  import op_pipe_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z
);

  // One extra bit holds the carry-out of the add and the borrow of the subtract.
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    y = '0;
    z = '0;
    case (op)
      OP_LOGIC: begin
        y = a & b;
        z = a | b;
      end
      OP_PARITY: begin
        y = a ^ b;
        z = ~(a ^ b);
      end
      OP_ADD: begin
        y    = w_sum[WIDTH-1:0];
        z[0] = w_sum[WIDTH];
      end
      default: begin
        y    = w_diff[WIDTH-1:0];
        z[0] = w_diff[WIDTH];
      end
    endcase
  end

endmodule : op_pipe_alu

// File: rtl/op_pipe.sv
// Registered operation pipeline: ALU result captured in stage 1 and shifted
// through STAGES registers with a travelling valid bit and a saturating count.
module op_pipe
  import op_pipe_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic             out_valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] w_alu_y;
  logic [WIDTH-1:0] w_alu_z;

  op_pipe_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (a),
    .b  (b),
    .op (op),
    .y  (w_alu_y),
    .z  (w_alu_z)
  );

  logic [STAGES-1:0][WIDTH-1:0] r_y;
  logic [STAGES-1:0][WIDTH-1:0] r_z;
  logic [STAGES-1:0]            r_v;
  logic [CNT_W-1:0]             r_count;

  // Entry 0 is the ALU output; entry i is what stage i loads on an advancing edge.
  logic [STAGES:0][WIDTH-1:0] w_shift_y;
  logic [STAGES:0][WIDTH-1:0] w_shift_z;
  logic [STAGES:0]            w_shift_v;
  logic                       w_load_v;

  assign w_shift_y = {r_y, w_alu_y};
  assign w_shift_z = {r_z, w_alu_z};
  assign w_shift_v = {r_v, in_valid};
  assign w_load_v  = w_shift_v[STAGES-1];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage sees the pre-edge value of its predecessor.
    if (!rst_n) begin
      r_y     <= '0;
      r_z     <= '0;
      r_v     <= '0;
      r_count <= '0;
    end else if (en) begin
      r_y <= w_shift_y[STAGES-1:0];
      r_z <= w_shift_z[STAGES-1:0];
      r_v <= w_shift_v[STAGES-1:0];
      if (w_load_v && (r_count != CNT_MAX)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign y         = r_y[STAGES-1];
  assign z         = r_z[STAGES-1];
  assign out_valid = r_v[STAGES-1];
  assign count     = r_count;

endmodule : op_pipe

// File: tb/tb_op_pipe.sv
// Scoreboard bench for op_pipe: one WIDTH=2/STAGES=1 and one WIDTH=4/STAGES=3
// instance, with directed vectors and queue-based output monitors.
module tb_op_pipe;
  import op_pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instance 0: WIDTH=2, STAGES=1 ----------------
  logic       rst0 = 1'b0, en0 = 1'b1, iv0 = 1'b0;
  logic [1:0] a0 = '0, b0 = '0, op0 = '0;
  logic [1:0] y0, z0;
  logic       ov0;
  logic [7:0] cnt0;

  op_pipe #(.WIDTH(2), .STAGES(1)) u_dut0 (
    .clk(clk), .rst_n(rst0), .en(en0), .in_valid(iv0), .a(a0), .b(b0), .op(op0),
    .y(y0), .z(z0), .out_valid(ov0), .count(cnt0)
  );

  // ---------------- instance 1: WIDTH=4, STAGES=3 ----------------
  logic       rst1 = 1'b0, en1 = 1'b1, iv1 = 1'b0;
  logic [3:0] a1 = '0, b1 = '0;
  logic [1:0] op1 = '0;
  logic [3:0] y1, z1;
  logic       ov1;
  logic [7:0] cnt1;

  op_pipe #(.WIDTH(4), .STAGES(3)) u_dut1 (
    .clk(clk), .rst_n(rst1), .en(en1), .in_valid(iv1), .a(a1), .b(b1), .op(op1),
    .y(y1), .z(z1), .out_valid(ov1), .count(cnt1)
  );

  // ---------------- scoreboards ----------------
  logic [3:0] q0[$];   // {y,z}
  logic [7:0] q1[$];   // {y,z}
  logic adv0 = 1'b0, rsted0 = 1'b0, adv1 = 1'b0, rsted1 = 1'b0;
  int   exp_cnt0 = 0, exp_cnt1 = 0;

  always @(posedge clk) begin
    adv0   = en0 && rst0;
    rsted0 = !rst0;
    adv1   = en1 && rst1;
    rsted1 = !rst1;
    if (!rst0) q0.delete();
    if (!rst1) q1.delete();
  end

  always @(negedge clk) begin
    logic [3:0] e0;
    if (rsted0) begin
      exp_cnt0 = 0;
      check("d0_rst_y", 32'(y0), 0);
      check("d0_rst_z", 32'(z0), 0);
      check("d0_rst_ov", 32'(ov0), 0);
      check("d0_rst_cnt", 32'(cnt0), 0);
    end else if (adv0) begin
      if (ov0) begin
        if (q0.size() == 0) begin
          check("d0_unexpected_result", 32'(ov0), 0);
        end else begin
          e0 = q0.pop_front();
          check("d0_y", 32'(y0), 32'(e0[3:2]));
          check("d0_z", 32'(z0), 32'(e0[1:0]));
        end
        if (exp_cnt0 != 255) exp_cnt0++;
      end
      check("d0_count", 32'(cnt0), 32'(exp_cnt0));
    end
  end

  always @(negedge clk) begin
    logic [7:0] e1;
    if (rsted1) begin
      exp_cnt1 = 0;
      check("d1_rst_y", 32'(y1), 0);
      check("d1_rst_z", 32'(z1), 0);
      check("d1_rst_ov", 32'(ov1), 0);
      check("d1_rst_cnt", 32'(cnt1), 0);
    end else if (adv1) begin
      if (ov1) begin
        if (q1.size() == 0) begin
          check("d1_unexpected_result", 32'(ov1), 0);
        end else begin
          e1 = q1.pop_front();
          check("d1_y", 32'(y1), 32'(e1[7:4]));
          check("d1_z", 32'(z1), 32'(e1[3:0]));
        end
        if (exp_cnt1 != 255) exp_cnt1++;
      end
      check("d1_count", 32'(cnt1), 32'(exp_cnt1));
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a falling edge: drive, record expectation, wait one cycle.
  task automatic issue0(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
                        input logic v, input logic [1:0] ey, input logic [1:0] ez);
    a0 = a; b0 = b; op0 = op; iv0 = v;
    if (v && en0 && rst0) q0.push_back({ey, ez});
    @(negedge clk);
  endtask

  task automatic issue1(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                        input logic v, input logic [3:0] ey, input logic [3:0] ez);
    a1 = a; b1 = b; op1 = op; iv1 = v;
    if (v && en1 && rst1) q1.push_back({ey, ez});
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] sy, sz;
    logic       sv;
    logic [7:0] sc;

    // ---- instance 0 ----
    repeat (2) @(negedge clk);
    rst0 = 1'b1;
    issue0(2'd1, 2'd0, OP_LOGIC, 1'b1, 2'b00, 2'b01);
    check("d0_first_y", 32'(y0), 32'h0);
    check("d0_first_z", 32'(z0), 32'h1);
    check("d0_first_ov", 32'(ov0), 1);
    check("d0_first_cnt", 32'(cnt0), 1);
    a0 = 2'd0; b0 = 2'd1; op0 = OP_PARITY; iv0 = 1'b1;
    q0.push_back({2'b01, 2'b10});
    #3;
    check("d0_midcycle_y", 32'(y0), 32'h0);
    check("d0_midcycle_z", 32'(z0), 32'h1);
    @(negedge clk);
    check("d0_parity_y", 32'(y0), 32'h1);
    check("d0_parity_z", 32'(z0), 32'h2);
    issue0(2'd3, 2'd1, OP_ADD, 1'b1, 2'd0, 2'd1);
    issue0(2'd1, 2'd2, OP_SUB, 1'b1, 2'd3, 2'd1);
    issue0(2'd3, 2'd3, OP_LOGIC, 1'b0, 2'd0, 2'd0);
    check("d0_invalid_ov", 32'(ov0), 0);
    check("d0_cnt_after", 32'(cnt0), 4);

    // ---- instance 1: latency ----
    rst1 = 1'b1;
    issue1(4'hF, 4'h1, OP_ADD, 1'b1, 4'h0, 4'h1);
    check("d1_lat_e0_ov", 32'(ov1), 0);
    issue1(4'h2, 4'h5, OP_SUB, 1'b1, 4'hD, 4'h1);
    check("d1_lat_e1_ov", 32'(ov1), 0);
    issue1(4'h0, 4'h0, OP_LOGIC, 1'b0, 4'h0, 4'h0);
    check("d1_lat_e2_ov", 32'(ov1), 1);
    check("d1_lat_e2_y", 32'(y1), 32'h0);
    check("d1_lat_e2_z", 32'(z1), 32'h1);

    // ---- back-to-back ----
    issue1(4'hC, 4'hA, OP_LOGIC,  1'b1, 4'h8, 4'hE);
    issue1(4'hC, 4'hA, OP_PARITY, 1'b1, 4'h6, 4'h9);
    issue1(4'h7, 4'h8, OP_ADD,    1'b1, 4'hF, 4'h0);
    issue1(4'h8, 4'h8, OP_SUB,    1'b1, 4'h0, 4'h0);
    issue1(4'h0, 4'h1, OP_SUB,    1'b1, 4'hF, 4'h1);
    issue1(4'h8, 4'h8, OP_ADD,    1'b1, 4'h0, 4'h1);

    // ---- stall mid-stream ----
    issue1(4'h3, 4'h5, OP_LOGIC,  1'b1, 4'h1, 4'h7);
    issue1(4'h3, 4'h5, OP_PARITY, 1'b1, 4'h6, 4'h9);
    sy = y1; sz = z1; sv = ov1; sc = cnt1;
    en1 = 1'b0;
    a1 = 4'h9; b1 = 4'h9; op1 = OP_ADD; iv1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("d1_stall_y", 32'(y1), 32'(sy));
      check("d1_stall_z", 32'(z1), 32'(sz));
      check("d1_stall_ov", 32'(ov1), 32'(sv));
      check("d1_stall_cnt", 32'(cnt1), 32'(sc));
    end
    en1 = 1'b1;
    repeat (3) issue1(4'h0, 4'h0, OP_LOGIC, 1'b0, 4'h0, 4'h0);

    // ---- reset with two results in flight ----
    issue1(4'h1, 4'h2, OP_PARITY, 1'b1, 4'h3, 4'hC);
    issue1(4'hF, 4'h0, OP_LOGIC,  1'b1, 4'h0, 4'hF);
    rst1 = 1'b0;
    @(negedge clk);
    rst1 = 1'b1;
    repeat (4) issue1(4'h0, 4'h0, OP_LOGIC, 1'b0, 4'h0, 4'h0);
    check("d1_post_rst_cnt", 32'(cnt1), 0);

    // ---- saturation ----
    repeat (300) issue1(4'h5, 4'h5, OP_LOGIC, 1'b1, 4'h5, 4'h5);
    repeat (4) issue1(4'h5, 4'h5, OP_LOGIC, 1'b0, 4'h0, 4'h0);
    check("d1_sat_cnt", 32'(cnt1), 255);
    check("d1_sat_ov", 32'(ov1), 0);

    check("d0_queue_drained", q0.size(), 0);
    check("d1_queue_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule : tb_op_pipe
